ps2_mouse_packet_decoder: RTL and testbench
===========================================

// Module: ps2_mouse_packet_decoder
// PURPOSE
//  Consumes bytes from the PS/2 serial receiver stage and assembles standard 3-byte mouse packets.
//  Accumulates 9-bit signed X/Y deltas into an absolute cursor position, clamped to the visible area.
//  Exposes left/right button state to the VGA overlay logic.
//  Runs in the system clock domain and resynchronises itself on malformed or stalled packets.
// PARAMETERS
//  H_RES           640        visible width; mouse_x range is 0..H_RES-1
//  V_RES           480        visible height; mouse_y range is 0..V_RES-1
//  TIMEOUT_CYCLES  2_500_000  max clk cycles between bytes of one packet (25 ms @ 100 MHz)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  rx_byte      in   8   received byte, valid when rx_valid=1
//  rx_valid     in   1   1-cycle strobe: rx_byte holds a new byte
//  rx_err       in   1   1-cycle strobe: upstream framing/parity error
//  mouse_x      out  10  cursor X, unsigned
//  mouse_y      out  10  cursor Y, unsigned, 0 = top row
//  left_click   out  1   byte0 bit0 of last accepted packet
//  right_click  out  1   byte0 bit1 of last accepted packet
//  pkt_valid    out  1   1-cycle pulse when a packet has been applied
//  sync_err     out  1   1-cycle pulse on a dropped byte or an aborted packet
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - mouse_x=H_RES/2, mouse_y=V_RES/2, buttons=0, pkt_valid=0, sync_err=0.
//   - FSM=WAIT_B0; timeout counter=0.
//  FSM states: WAIT_B0 -> WAIT_B1 -> WAIT_B2 -> WAIT_B0.
//   - WAIT_B0: byte with bit3=1 is latched as b0, go to WAIT_B1.
//   - WAIT_B0: byte with bit3=0 is dropped, sync_err pulses, FSM stays in WAIT_B0.
//   - WAIT_B1: latch b1 (X delta low byte), go to WAIT_B2.
//   - WAIT_B2: latch b2 (Y delta low byte), apply the packet, go to WAIT_B0.
//  Packet apply (registered, outputs change 1 clk after the b2 strobe):
//   - dx = signed {b0[4], b1}; dy = signed {b0[5], b2}; both 9-bit, range -256..255.
//   - Compute in 12-bit signed: x' = mouse_x + dx; y' = mouse_y - dy (PS/2 +Y is up).
//   - Clamp: x' < 0 -> 0; x' > H_RES-1 -> H_RES-1. Same rule for y' with V_RES.
//   - b0[6] (X overflow) set: X unchanged. b0[7] (Y overflow) set: Y unchanged.
//   - Buttons always update from b0[1:0].
//   - pkt_valid pulses in the same cycle the outputs change.
//  Timeout:
//   - Counter runs only in WAIT_B1/WAIT_B2 and clears on every accepted byte.
//   - Reaching TIMEOUT_CYCLES with rx_valid=0: abort to WAIT_B0, sync_err pulse, no output change.
//  rx_err:
//   - In any state: abort to WAIT_B0, discard partial packet, sync_err pulse.
//   - In WAIT_B0 the pulse still fires.
//  Simultaneous events:
//   - rx_err and rx_valid together: error wins, byte discarded.
//   - rx_valid and timeout expiry in the same cycle: byte is accepted, no abort.
//  Back-to-back bytes (rx_valid on consecutive cycles) are accepted; there is no backpressure.
//  Reset mid-packet discards all partial state.
// TESTING
//  1. Release rst_n, no input -> mouse_x=320, mouse_y=240, buttons 0, no pulses.
//  2. Bytes 0x09,0x05,0x03 -> 1 clk after 3rd: x=325, y=237, left_click=1, one pkt_valid pulse.
//  3. From x=320 send 0x18,0x00,0x00 twice -> x=64, then x=0 (clamped); y unchanged both times.
//  4. Byte 0x00 in WAIT_B0 -> sync_err pulse, dropped; then 0x08,0x01,0x00 -> x+1, y unchanged.
//  5. Send 0x08,0x10, idle TIMEOUT_CYCLES+1, then 0x08,0x01,0x01 -> sync_err once; final x+1, y-1.
//  6. Bytes 0x4A,0x7F,0x02 -> x unchanged (overflow), y-2, right_click=1; rx_err mid-packet -> abort.

Source files
------------

// File: rtl/ps2_mouse_packet_decoder.sv
// PS/2 mouse packet decoder: assembles 3-byte packets from the receiver stage and
// integrates the signed deltas into a clamped absolute cursor with button state.
module ps2_mouse_packet_decoder #(
  parameter int H_RES          = 640,
  parameter int V_RES          = 480,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic [9:0] mouse_x,
  output logic [9:0] mouse_y,
  output logic       left_click,
  output logic       right_click,
  output logic       pkt_valid,
  output logic       sync_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0] X_MAX  = 10'(H_RES - 1);
  localparam logic [9:0] Y_MAX  = 10'(V_RES - 1);
  localparam logic [9:0] X_HOME = 10'(H_RES / 2);
  localparam logic [9:0] Y_HOME = 10'(V_RES / 2);

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      b0_q, b0_d;
  logic [7:0]      b1_q, b1_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [9:0]      mouse_x_q, mouse_x_d;
  logic [9:0]      mouse_y_q, mouse_y_d;
  logic            left_q, left_d;
  logic            right_q, right_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic            sync_err_q, sync_err_d;

  logic signed [11:0] dx_s;
  logic signed [11:0] dy_neg_s;
  logic               timeout_s;

  // Adds a signed delta to a position and saturates into 0..max.
  function automatic logic [9:0] clamp_add(input logic [9:0] pos,
                                           input logic signed [11:0] delta,
                                           input logic [9:0] max);
    logic signed [11:0] sum;
    sum = $signed({2'b00, pos}) + delta;
    if (sum < 12'sd0) begin
      clamp_add = 10'd0;
    end else if (sum > $signed({2'b00, max})) begin
      clamp_add = max;
    end else begin
      clamp_add = sum[9:0];
    end
  endfunction

  // PS/2 +Y points up while screen rows grow downward, so Y gets the negated delta.
  assign dx_s      = $signed({{3{b0_q[4]}}, b1_q});
  assign dy_neg_s  = 12'sd0 - $signed({{3{b0_q[5]}}, rx_byte});
  assign timeout_s = (state_q != WAIT_B0) && (cnt_q == TO_LAST);

  // Next-state, packet assembly, apply and pulse generation.
  always_comb begin
    state_d     = state_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    cnt_d       = {CW{1'b0}};
    mouse_x_d   = mouse_x_q;
    mouse_y_d   = mouse_y_q;
    left_d      = left_q;
    right_d     = right_q;
    pkt_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    if (rx_err) begin
      state_d    = WAIT_B0;
      sync_err_d = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        WAIT_B0: begin
          if (rx_byte[3]) begin
            b0_d    = rx_byte;
            state_d = WAIT_B1;
          end else begin
            sync_err_d = 1'b1;
          end
        end
        WAIT_B1: begin
          b1_d    = rx_byte;
          state_d = WAIT_B2;
        end
        WAIT_B2: begin
          if (b0_q[6]) begin
            mouse_x_d = mouse_x_q;
          end else begin
            mouse_x_d = clamp_add(mouse_x_q, dx_s, X_MAX);
          end
          if (b0_q[7]) begin
            mouse_y_d = mouse_y_q;
          end else begin
            mouse_y_d = clamp_add(mouse_y_q, dy_neg_s, Y_MAX);
          end
          left_d      = b0_q[0];
          right_d     = b0_q[1];
          pkt_valid_d = 1'b1;
          state_d     = WAIT_B0;
        end
        default: begin
          state_d = WAIT_B0;
        end
      endcase
    end else if (timeout_s) begin
      state_d    = WAIT_B0;
      sync_err_d = 1'b1;
    end else if (state_q != WAIT_B0) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_B0;
      b0_q        <= 8'd0;
      b1_q        <= 8'd0;
      cnt_q       <= {CW{1'b0}};
      mouse_x_q   <= X_HOME;
      mouse_y_q   <= Y_HOME;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      pkt_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      cnt_q       <= cnt_d;
      mouse_x_q   <= mouse_x_d;
      mouse_y_q   <= mouse_y_d;
      left_q      <= left_d;
      right_q     <= right_d;
      pkt_valid_q <= pkt_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign mouse_x     = mouse_x_q;
  assign mouse_y     = mouse_y_q;
  assign left_click  = left_q;
  assign right_click = right_q;
  assign pkt_valid   = pkt_valid_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Scoreboard bench for ps2_mouse_packet_decoder: a packet-level reference model
// queues expected pulses; a negedge monitor pops and compares them.
module tb_ps2_mouse_packet_decoder;

  localparam int H  = 640;
  localparam int V  = 480;
  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic       rx_valid = 1'b0;
  logic       rx_err = 1'b0;
  logic [9:0] mouse_x, mouse_y;
  logic       left_click, right_click, pkt_valid, sync_err;

  ps2_mouse_packet_decoder #(.H_RES(H), .V_RES(V), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .left_click(left_click),
    .right_click(right_click), .pkt_valid(pkt_valid), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_pkt;
    int x;
    int y;
    bit l;
    bit r;
  } ev_t;

  ev_t    exp_q[$];
  int     n_cmp = 0;
  int     n_fail = 0;

  // reference model state
  int     mx, my, gap;
  bit     ml, mr;
  byte unsigned pkt[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void push_ev(input bit is_pkt);
    ev_t e;
    e.is_pkt = is_pkt; e.x = mx; e.y = my; e.l = ml; e.r = mr;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    mx = H / 2; my = V / 2; ml = 1'b0; mr = 1'b0; gap = 0;
    pkt.delete();
  endfunction

  function automatic void model_step(input bit v, input bit e, input byte unsigned b);
    int dx, dy;
    if (e) begin
      pkt.delete(); gap = 0; push_ev(1'b0);
    end else if (v) begin
      if (pkt.size() == 0 && b[3] == 1'b0) begin
        push_ev(1'b0);
      end else begin
        pkt.push_back(b); gap = 0;
        if (pkt.size() == 3) begin
          dx = pkt[0][4] ? int'(pkt[1]) - 256 : int'(pkt[1]);
          dy = pkt[0][5] ? int'(pkt[2]) - 256 : int'(pkt[2]);
          if (!pkt[0][6]) mx = clampi(mx + dx, H - 1);
          if (!pkt[0][7]) my = clampi(my - dy, V - 1);
          ml = pkt[0][0]; mr = pkt[0][1];
          pkt.delete();
          push_ev(1'b1);
        end
      end
    end else if (pkt.size() > 0) begin
      gap++;
      if (gap >= TO) begin
        pkt.delete(); gap = 0; push_ev(1'b0);
      end
    end
  endfunction

  task automatic step(input bit v, input bit e, input logic [7:0] b);
    rx_valid = v; rx_err = e; rx_byte = b;
    @(posedge clk); #1;
    model_step(v, e, b);
    rx_valid = 1'b0; rx_err = 1'b0; rx_byte = 8'd0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, 1'b0, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && (pkt_valid || sync_err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("pulse_kind_pkt", int'(pkt_valid), int'(e.is_pkt));
        chk("pulse_kind_err", int'(sync_err), int'(!e.is_pkt));
        chk("mouse_x", int'(mouse_x), e.x);
        chk("mouse_y", int'(mouse_y), e.y);
        chk("left_click", int'(left_click), int'(e.l));
        chk("right_click", int'(right_click), int'(e.r));
      end
    end
  end

  initial begin
    model_reset();
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // 1: reset state
    chk("rst_x", int'(mouse_x), 320);
    chk("rst_y", int'(mouse_y), 240);
    chk("rst_btn", int'({left_click, right_click}), 0);
    chk("rst_pulses", int'({pkt_valid, sync_err}), 0);
    idle(3);
    // 2: basic packet
    send(8'h09); send(8'h05); send(8'h03);
    chk("t2_x", int'(mouse_x), 325);
    chk("t2_y", int'(mouse_y), 237);
    chk("t2_left", int'(left_click), 1);
    chk("t2_pv", int'(pkt_valid), 1);
    idle(1);
    chk("t2_pv_once", int'(pkt_valid), 0);
    // reset mid-packet, then 3: negative X clamps at 0
    send(8'h09); send(8'h05); idle(1);
    do_reset();
    chk("mid_rst_x", int'(mouse_x), 320);
    send(8'h18); send(8'h00); send(8'h00);
    chk("t3_x1", int'(mouse_x), 64);
    send(8'h18); send(8'h00); send(8'h00);
    chk("t3_x2", int'(mouse_x), 0);
    chk("t3_y", int'(mouse_y), 240);
    // 4: dropped byte then valid packet
    send(8'h00); send(8'h08); send(8'h01); send(8'h00);
    chk("t4_x", int'(mouse_x), 1);
    // 5: timeout abort, then packet
    send(8'h08); send(8'h10); idle(TO + 1);
    send(8'h08); send(8'h01); send(8'h01);
    chk("t5_x", int'(mouse_x), 2);
    chk("t5_y", int'(mouse_y), 239);
    // timeout boundary: gap of TO-1 idles still accepted
    send(8'h08); idle(TO - 1); send(8'h02); idle(TO - 1); send(8'h00);
    chk("to_edge_x", int'(mouse_x), 4);
    // 6: overflow and right click; rx_err mid-packet and with rx_valid
    send(8'h4A); send(8'h7F); send(8'h02);
    chk("t6_x", int'(mouse_x), 4);
    chk("t6_y", int'(mouse_y), 237);
    chk("t6_right", int'(right_click), 1);
    send(8'h08); send(8'h01); step(1'b0, 1'b1, 8'h00);
    send(8'h08); step(1'b1, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h00);
    send(8'h08); send(8'h01); send(8'h01);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int sel;
      logic [7:0] b;
      sel = int'($urandom_range(0, 99));
      b = 8'($urandom);
      if (pkt.size() == 0 && sel < 85) b[3] = 1'b1;
      if (sel < 4) step(1'b0, 1'b1, 8'h00);
      else if (sel < 7) step(1'b1, 1'b1, b);
      else send(b);
      sel = int'($urandom_range(0, 99));
      if (sel < 4) idle(TO + int'($urandom_range(0, 4)));
      else if (sel < 8) idle(TO - 1);
      else idle(int'($urandom_range(0, 3)));
    end
    idle(TO + 4);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
